bj_table_ctrl: RTL and testbench

Parametrised blackjack round controller for one dealer and `NUM_PLAYERS` seats. It sits between the card RNG and the score displays. It deals the opening hands, then sequences each player's hit/stand turn in seat order. After the players it runs the dealer's automatic draw and settles a win/lose/push result per seat. It supersedes the single-player score FSM and adds multi-seat play, a card handshake, configurable limits and per-seat results.

---
 rtl/bj_pkg.sv | 14 +
 rtl/bj_hand_acc.sv | 50 +++++
 rtl/bj_table_ctrl.sv | 142 ++++++++++++++
 tb/tb_bj_table_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// bj_pkg: shared round states, per-seat result codes and card scoring for the blackjack table
package bj_pkg;
    typedef enum logic [2:0] {IDLE, DEAL, PLAY, DRAW, DEALER, SETTLE, DONE} state_e;
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_PUSH = 2'b11;
    localparam logic [3:0] CARD_ACE = 4'd1;
    localparam logic [3:0] CARD_MAX = 4'd13;
    // faces count 10; out-of-range codes score 0 and are treated as discards
    function automatic logic [3:0] card_points(input logic [3:0] c);
        return (c == 4'd0 || c > CARD_MAX) ? 4'd0 : (c > 4'd10 ? 4'd10 : c);
    endfunction
endpackage

// File: rtl/bj_hand_acc.sv
// bj_hand_acc: one hand's running total and bust flags; soft-ace tracking when BJ_SOFT_ACE_EN is defined
module bj_hand_acc
    import bj_pkg::*;
#(
    parameter int SCORE_W    = 5,
    parameter int BUST_LIMIT = 21
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               add_i,
    input  logic [3:0]         card_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               bust_o,
    output logic               next_bust_o
);
    localparam logic [SCORE_W:0] LIM = (SCORE_W+1)'(BUST_LIMIT);
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    logic               take;
    assign take = add_i && card_points(card_i) != 4'd0;
`ifdef BJ_SOFT_ACE_EN
    logic             soft_q, soft_d, ace_hi, over;
    logic [SCORE_W:0] raw;
    // an ace takes 11 when it fits; a soft hand that overflows drops its 11 back to 1
    always_comb begin
        ace_hi = card_i == CARD_ACE && {1'b0, score_q} + (SCORE_W+1)'(11) <= LIM;
        raw    = {1'b0, score_q} + (ace_hi ? (SCORE_W+1)'(11) : (SCORE_W+1)'(card_points(card_i)));
        over   = soft_q && raw > LIM;
        sum    = over ? raw - (SCORE_W+1)'(10) : raw;
        soft_d = clr_i ? 1'b0 : take ? (ace_hi || (soft_q && !over)) : soft_q;
    end
    // soft flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) soft_q <= 1'b0;
        else         soft_q <= soft_d;
    end
`else
    assign sum = {1'b0, score_q} + (SCORE_W+1)'(card_points(card_i));
`endif
    assign score_d     = clr_i ? '0 : take ? sum[SCORE_W-1:0] : score_q;
    assign score_o     = score_q;
    assign bust_o      = {1'b0, score_q} > LIM;
    assign next_bust_o = sum > LIM;
    // hand total register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) score_q <= '0;
        else         score_q <= score_d;
    end
endmodule

// File: rtl/bj_table_ctrl.sv
// bj_table_ctrl: multi-seat blackjack round sequencer (deal, player turns, dealer draw, settle); BJ_SOFT_ACE_EN enables soft aces
module bj_table_ctrl
    import bj_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int BUST_LIMIT   = 21,
    parameter int DEALER_STAND = 17,
    parameter int SCORE_W      = 5,
    localparam int AW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           hit,
    input  logic                           stand,
    input  logic                           card_valid,
    input  logic [3:0]                     card_value,
    output logic                           card_ready,
    output logic [AW-1:0]                  active_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0]             dealer_score,
    output logic [2*NUM_PLAYERS-1:0]       result,
    output logic                           dealing_cards,
    output logic                           game_finished
);
    localparam int DW = $clog2(2*NUM_PLAYERS+2);
    localparam logic [DW-1:0]      DLAST = DW'(2*NUM_PLAYERS+1);
    localparam logic [AW-1:0]      LAST  = AW'(NUM_PLAYERS-1);
    localparam logic [SCORE_W-1:0] LIM   = SCORE_W'(BUST_LIMIT);
    localparam logic [SCORE_W-1:0] STAND = SCORE_W'(DEALER_STAND);

    state_e                   state_q, state_d;
    logic [AW-1:0]            seat_q, seat_d;
    logic [DW-1:0]            deal_q, deal_d;
    logic [2*NUM_PLAYERS-1:0] res_q, res_d;
    logic [SCORE_W-1:0]       score [NUM_PLAYERS+1];
    logic [SCORE_W-1:0]       cur_score;
    logic [NUM_PLAYERS:0]     bust, nbust, add, sel;
    logic                     clr, xfer, take, dealer_stop, others_bust, cur_nbust, adv, bust_now;
    int                       tgt;

    assign clr         = start && (state_q == IDLE || state_q == DONE);
    assign xfer        = card_valid && card_ready;
    assign take        = xfer && card_points(card_value) != 4'd0;
    assign dealer_stop = score[NUM_PLAYERS] >= STAND;
    assign sel         = (NUM_PLAYERS+1)'(1) << seat_q;
    assign cur_nbust   = |(nbust & sel);

    for (genvar i = 0; i <= NUM_PLAYERS; i++) begin : g_hand
        bj_hand_acc #(.SCORE_W(SCORE_W), .BUST_LIMIT(BUST_LIMIT)) u_hand (
            .clk_i(CLOCK_50), .rst_ni(resetn), .clr_i(clr), .add_i(add[i]), .card_i(card_value),
            .score_o(score[i]), .bust_o(bust[i]), .next_bust_o(nbust[i])
        );
        if (i < NUM_PLAYERS) begin : g_out
            assign player_score[i*SCORE_W +: SCORE_W] = score[i];
        end
    end

    // route the offered card to the hand it belongs to and pick out the active seat
    always_comb begin
        tgt         = deal_q > DW'(NUM_PLAYERS) ? int'(deal_q) - NUM_PLAYERS - 1 : int'(deal_q);
        cur_score   = '0;
        others_bust = 1'b1;
        for (int i = 0; i <= NUM_PLAYERS; i++)
            add[i] = xfer && ((state_q == DEAL && tgt == i) || (state_q == DRAW && sel[i]) ||
                              (state_q == DEALER && i == NUM_PLAYERS));
        for (int i = 0; i < NUM_PLAYERS; i++)
            cur_score = sel[i] ? score[i] : cur_score;
        for (int i = 0; i < NUM_PLAYERS - 1; i++)
            others_bust &= bust[i];
    end

    // state and round-bookkeeping registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            seat_q  <= '0;
            deal_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            seat_q  <= seat_d;
            deal_q  <= deal_d;
            res_q   <= res_d;
        end
    end

    // next state: deal counting, seat turns with stand priority, dealer draw and settlement
    always_comb begin
        state_d  = state_q;
        seat_d   = seat_q;
        deal_d   = deal_q;
        res_d    = res_q;
        adv      = 1'b0;
        bust_now = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = DEAL;
                seat_d  = '0;
                deal_d  = '0;
                res_d   = '0;
            end
            DEAL: if (take) begin
                deal_d  = deal_q + DW'(1);
                state_d = deal_q == DLAST ? PLAY : DEAL;
            end
            PLAY: if (stand || cur_score == LIM) adv = 1'b1;
                  else if (hit) state_d = DRAW;
            DRAW: if (take) begin
                adv      = cur_nbust;
                bust_now = cur_nbust;
                state_d  = PLAY;
            end
            DEALER: if (dealer_stop) state_d = SETTLE;
            SETTLE: begin
                state_d = DONE;
                for (int i = 0; i < NUM_PLAYERS; i++)
                    res_d[2*i +: 2] = bust[i] ? RES_LOSE : bust[NUM_PLAYERS] ? RES_WIN :
                                      score[i] > score[NUM_PLAYERS] ? RES_WIN :
                                      score[i] < score[NUM_PLAYERS] ? RES_LOSE : RES_PUSH;
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (seat_q == LAST) state_d = (others_bust && bust_now) ? SETTLE : DEALER;
            else begin
                seat_d  = seat_q + AW'(1);
                state_d = PLAY;
            end
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        card_ready    = state_q == DEAL || state_q == DRAW || (state_q == DEALER && !dealer_stop);
        dealing_cards = card_ready;
        game_finished = state_q == DONE;
        active_player = seat_q;
        dealer_score  = score[NUM_PLAYERS];
        result        = res_q;
    end
endmodule

// File: tb/tb_bj_table_ctrl.sv
// tb_bj_table_ctrl: directed round-by-round check of the two-seat blackjack controller
module tb_bj_table_ctrl;
    logic       clk = 1'b0, rstn = 1'b0, start = 1'b0, hit = 1'b0, stand = 1'b0, cv = 1'b0;
    logic [3:0] cval = 4'd0;
    logic       card_ready, dealing_cards, game_finished;
    logic [0:0] active_player;
    logic [9:0] player_score;
    logic [4:0] dealer_score;
    logic [3:0] result;
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    bj_table_ctrl #(.NUM_PLAYERS(2)) dut (
        .CLOCK_50(clk), .resetn(rstn), .start(start), .hit(hit), .stand(stand),
        .card_valid(cv), .card_value(cval), .card_ready(card_ready), .active_player(active_player),
        .player_score(player_score), .dealer_score(dealer_score), .result(result),
        .dealing_cards(dealing_cards), .game_finished(game_finished)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic h, input logic s, input logic st);
        hit = h; stand = s; start = st;
        @(negedge clk);
        hit = 1'b0; stand = 1'b0; start = 1'b0;
    endtask

    task automatic give_card(input logic [3:0] v);
        int n = 0;
        while (!card_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("card_ready_wait", card_ready, 1);
        cv = 1'b1; cval = v;
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic deal6(input logic [3:0] a, b, c, d, e, f);
        give_card(a); give_card(b); give_card(c); give_card(d); give_card(e); give_card(f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", card_ready, 0);
        check("rst_active", active_player, 0);
        check("rst_pscore", player_score, 0);
        check("rst_dscore", dealer_score, 0);
        check("rst_result", result, 0);
        check("rst_finished", game_finished, 0);
        rstn = 1'b1;
        @(negedge clk);
        // round 1: seat0 17, seat1 18, dealer 16 draws 5 -> 21, both lose
        press(0, 0, 1);
        deal6(10, 9, 10, 7, 9, 6);
        check("r1_play_ready", card_ready, 0);
        check("r1_pscore", player_score, {5'd18, 5'd17});
        check("r1_dscore", dealer_score, 16);
        check("r1_active0", active_player, 0);
        press(0, 1, 0);
        check("r1_active1", active_player, 1);
        press(0, 1, 0);
        check("r1_dealer_ready", card_ready, 1);
        check("r1_dealing", dealing_cards, 1);
        give_card(5);
        check("r1_dealer_stop", card_ready, 0);
        repeat (2) @(negedge clk);
        check("r1_finished", game_finished, 1);
        check("r1_dscore21", dealer_score, 21);
        check("r1_result", result, 4'b1010);
        // round 2 from DONE: discarded card, seat0 busts, hit+stand on seat1, push
        press(0, 0, 1);
        check("r2_clear_p", player_score, 0);
        check("r2_clear_res", result, 0);
        give_card(10); give_card(9); give_card(10);
        give_card(14);
        check("r2_discard_p", player_score, {5'd9, 5'd10});
        check("r2_discard_d", dealer_score, 10);
        check("r2_discard_ready", card_ready, 1);
        give_card(5); give_card(8); give_card(7);
        check("r2_pscore", player_score, {5'd17, 5'd15});
        check("r2_dscore", dealer_score, 17);
        press(1, 0, 0);
        check("r2_draw_ready", card_ready, 1);
        give_card(9);
        check("r2_bust_adv", active_player, 1);
        check("r2_bust_score", player_score, {5'd17, 5'd24});
        check("r2_play_ready", card_ready, 0);
        press(1, 1, 0);
        check("r2_hs_noready", card_ready, 0);
        check("r2_hs_finished", game_finished, 0);
        repeat (2) @(negedge clk);
        check("r2_finished", game_finished, 1);
        check("r2_result", result, 4'b1110);
        check("r2_hs_score", player_score, {5'd17, 5'd24});
        // round 3: every seat busts, dealer never draws
        press(0, 0, 1);
        deal6(10, 10, 10, 6, 5, 2);
        press(1, 0, 0);
        give_card(10);
        check("r3_adv", active_player, 1);
        press(1, 0, 0);
        give_card(10);
        check("r3_settle_ready", card_ready, 0);
        check("r3_settle_notdone", game_finished, 0);
        @(negedge clk);
        check("r3_finished", game_finished, 1);
        check("r3_dscore", dealer_score, 12);
        check("r3_result", result, 4'b1010);
        // round 4: ace handling, then reset in the middle of a draw
        press(0, 0, 1);
        deal6(1, 10, 10, 6, 10, 8);
`ifdef BJ_SOFT_ACE_EN
        check("r4_ace6", player_score, {5'd20, 5'd17});
`else
        check("r4_ace6", player_score, {5'd20, 5'd7});
`endif
        press(1, 0, 0);
        give_card(10);
        check("r4_hit10", player_score, {5'd20, 5'd17});
        check("r4_active0", active_player, 0);
        press(0, 1, 0);
        check("r4_active1", active_player, 1);
        press(1, 0, 0);
        check("r4_draw_ready", card_ready, 1);
        cv = 1'b1; cval = 4'd5;
        #2 rstn = 1'b0;
        #1;
        check("rst2_ready", card_ready, 0);
        check("rst2_pscore", player_score, 0);
        check("rst2_dscore", dealer_score, 0);
        check("rst2_active", active_player, 0);
        check("rst2_result", result, 0);
        check("rst2_finished", game_finished, 0);
        @(negedge clk);
        cv = 1'b0;
        check("rst2_noconsume", player_score, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst2_idle_ready", card_ready, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
